// File: rtl/iir_mcavg.sv
// Multi-channel exponential moving average. Each channel keeps an OW-bit
// running average, updated by avg += round((x - avg) >> lgalpha) once per
// accepted sample. Results come out one cycle later through a ready/valid
// output register.
module iir_mcavg #(
   parameter int unsigned IW          = 15,
   parameter int unsigned OW          = 16,
   parameter int unsigned NCH         = 4,
   parameter int unsigned CW          = 2,
   parameter int unsigned LW          = 4,
   parameter logic [OW-1:0] RESET_VALUE = '0,
   parameter bit          OPT_PRELOAD = 1'b1,
   parameter bit          OPT_ROUND   = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_areset_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [CW-1:0] i_chan,
   input  logic [IW-1:0] i_data,
   input  logic [LW-1:0] i_lgalpha,
   input  logic          i_clear,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [CW-1:0] o_chan,
   output logic [OW-1:0] o_data
);

   // Two guard bits: one so x - avg cannot wrap, one for the rounding offset.
   localparam int unsigned AW   = OW + 2;
   localparam int unsigned SMAX = OW - 1;

   logic [OW-1:0]        avg_q [NCH];
   logic [NCH-1:0]       primed_q;

   logic [NCH-1:0]       hit;
   logic                 chan_ok;
   logic                 accept;
   logic [OW-1:0]        avg_cur;
   logic                 primed_cur;
   logic [OW-1:0]        x;
   logic [OW-1:0]        upd;
   logic [31:0]          shamt;
   logic signed [AW-1:0] x_ext;
   logic signed [AW-1:0] avg_ext;
   logic signed [AW-1:0] rnd;
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] adj;

   // A new sample can enter whenever the output slot is free or draining.
   assign o_ready = (!o_valid || i_ready) && !i_clear;
   assign accept  = i_valid && o_ready;
   assign chan_ok = |hit;

   // Decode the channel and fetch its state; out-of-range channels match nothing.
   always_comb begin
      hit        = '0;
      avg_cur    = '0;
      primed_cur = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (32'(i_chan) == i) begin
            hit[i]     = 1'b1;
            avg_cur    = avg_q[i];
            primed_cur = primed_q[i];
         end
      end
   end

   // Compute the updated average for the selected channel.
   always_comb begin
      // Left-justify the sample into the OW-bit average format.
      x = OW'({i_data, {OW{1'b0}}} >> IW);
      if (32'(i_lgalpha) > SMAX) begin
         shamt = SMAX;
      end else begin
         shamt = 32'(i_lgalpha);
      end
      x_ext   = AW'($signed(x));
      avg_ext = AW'($signed(avg_cur));
      rnd     = '0;
      if (OPT_ROUND && shamt != 0) begin
         rnd = AW'(1) << (shamt - 1);
      end
      sum = x_ext - avg_ext + rnd;
      adj = sum >>> shamt;
      // |adj| never exceeds |x - avg|, so the sum always fits in OW bits.
      upd = OW'(avg_ext + adj);
      if (OPT_PRELOAD && !primed_cur) begin
         upd = x;
      end
   end

   // Per-channel averages and primed flags; clear wipes every channel.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         for (int i = 0; i < NCH; i++) begin
            avg_q[i] <= RESET_VALUE;
         end
         primed_q <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < NCH; i++) begin
            avg_q[i] <= RESET_VALUE;
         end
         primed_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < NCH; i++) begin
            if (hit[i]) begin
               avg_q[i]    <= upd;
               primed_q[i] <= 1'b1;
            end
         end
      end
   end

   // Output register: load on an in-range accept, drop on a bare transfer.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         o_valid <= 1'b0;
         o_chan  <= '0;
         o_data  <= '0;
      end else if (accept && chan_ok) begin
         o_valid <= 1'b1;
         o_chan  <= i_chan;
         o_data  <= upd;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iir_mcavg.sv
// Bench for iir_mcavg: three instances (preload+round, plain truncate,
// plain round) share stimulus and are checked against an arithmetic model.
module tb_iir_mcavg;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        i_areset_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [2:0]  i_chan = '0;
   logic [14:0] i_data = '0;
   logic [4:0]  i_lgalpha = '0;
   logic        i_clear = 1'b0;
   logic        i_ready = 1'b1;

   logic        ordy [NI];
   logic        ov   [NI];
   logic [2:0]  oc   [NI];
   logic [15:0] od   [NI];

   int nvec = 0;
   int nerr = 0;

   // Model state
   longint      m_avg [NI][4];
   bit          m_pr  [NI][4];
   bit          m_ov;
   logic [2:0]  m_oc;
   logic [15:0] m_od [NI];

   always #5 clk = ~clk;

   iir_mcavg #(.IW(15), .OW(16), .NCH(4), .CW(3), .LW(5), .RESET_VALUE(16'h0000),
      .OPT_PRELOAD(1'b1), .OPT_ROUND(1'b1)) u0 (
      .i_clk(clk), .i_areset_n(i_areset_n), .i_valid(i_valid), .o_ready(ordy[0]),
      .i_chan(i_chan), .i_data(i_data), .i_lgalpha(i_lgalpha), .i_clear(i_clear),
      .o_valid(ov[0]), .i_ready(i_ready), .o_chan(oc[0]), .o_data(od[0]));

   iir_mcavg #(.IW(15), .OW(16), .NCH(4), .CW(3), .LW(5), .RESET_VALUE(16'h0000),
      .OPT_PRELOAD(1'b0), .OPT_ROUND(1'b0)) u1 (
      .i_clk(clk), .i_areset_n(i_areset_n), .i_valid(i_valid), .o_ready(ordy[1]),
      .i_chan(i_chan), .i_data(i_data), .i_lgalpha(i_lgalpha), .i_clear(i_clear),
      .o_valid(ov[1]), .i_ready(i_ready), .o_chan(oc[1]), .o_data(od[1]));

   iir_mcavg #(.IW(15), .OW(16), .NCH(4), .CW(3), .LW(5), .RESET_VALUE(16'h0000),
      .OPT_PRELOAD(1'b0), .OPT_ROUND(1'b1)) u2 (
      .i_clk(clk), .i_areset_n(i_areset_n), .i_valid(i_valid), .o_ready(ordy[2]),
      .i_chan(i_chan), .i_data(i_data), .i_lgalpha(i_lgalpha), .i_clear(i_clear),
      .o_valid(ov[2]), .i_ready(i_ready), .o_chan(oc[2]), .o_data(od[2]));

   // Reference update: avg + floor((x - avg + half) / 2^s), s clamped to 15.
   function automatic longint model_upd(int k, longint avg, logic [14:0] d, int lg, bit primed);
      longint x;
      longint diff;
      int     s;
      bit     pre;
      bit     rnd;
      pre = (k == 0);
      rnd = (k != 1);
      x   = $signed(d);
      x   = x * 2;
      if (pre && !primed) return x;
      s    = (lg > 15) ? 15 : lg;
      diff = x - avg;
      if (rnd && s > 0) diff = diff + (longint'(1) << (s - 1));
      return avg + (diff >>> s);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int c = 0; c < 4; c++) begin
            m_avg[k][c] = 0;
            m_pr[k][c]  = 1'b0;
         end
         m_od[k] = '0;
      end
      m_ov = 1'b0;
      m_oc = '0;
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
   task automatic tick(input bit v, input logic [2:0] ch, input logic [14:0] d,
                       input logic [4:0] lg, input bit clr, input bit rdy);
      bit     acc;
      bit     hit;
      longint nv;
      @(negedge clk);
      i_valid = v; i_chan = ch; i_data = d; i_lgalpha = lg; i_clear = clr; i_ready = rdy;
      acc = v && (!m_ov || rdy) && !clr;
      hit = acc && (ch < 4);
      @(posedge clk);
      if (clr) begin
         for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
               m_avg[k][c] = 0;
               m_pr[k][c]  = 1'b0;
            end
         end
      end
      if (hit) begin
         for (int k = 0; k < NI; k++) begin
            nv = model_upd(k, m_avg[k][ch], d, int'(lg), m_pr[k][ch]);
            m_avg[k][ch] = nv;
            m_pr[k][ch]  = 1'b1;
            m_od[k]      = nv[15:0];
         end
         m_ov = 1'b1;
         m_oc = ch;
      end else if (rdy) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_areset_n = 1'b0;
      i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
      model_reset();
      @(negedge clk);
      i_areset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      i_areset_n = 1'b0;
      i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < NI; k++) begin
         nvec++;
         if (ov[k] !== 1'b0 || oc[k] !== 3'd0 || od[k] !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_outputs inst%0d: got v=%b c=%0d d=%h want v=0 c=0 d=0000",
                     k, ov[k], oc[k], od[k]);
         end
         nvec++;
         if (ordy[k] !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready inst%0d: got %b want 1", k, ordy[k]);
         end
      end
      @(negedge clk);
      i_areset_n = 1'b1;
   endtask

   task automatic test_preload();
      do_reset();
      tick(1'b1, 3'd2, 15'h1000, 5'd4, 1'b0, 1'b1);
      nvec++;
      if (ov[0] !== 1'b1 || oc[0] !== 3'd2 || od[0] !== 16'h2000) begin
         nerr++;
         $display("FAIL preload: got v=%b c=%0d d=%h want v=1 c=2 d=2000", ov[0], oc[0], od[0]);
      end
   endtask

   task automatic test_step();
      logic [15:0] exp_seq [3];
      exp_seq[0] = 16'h0100; exp_seq[1] = 16'h01F0; exp_seq[2] = 16'h02D1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 3'd0, 15'h0800, 5'd4, 1'b0, 1'b1);
         nvec++;
         if (ov[1] !== 1'b1 || od[1] !== exp_seq[i]) begin
            nerr++;
            $display("FAIL step%0d: got v=%b d=%h want v=1 d=%h", i, ov[1], od[1], exp_seq[i]);
         end
         nvec++;
         if (od[2] !== m_od[2]) begin
            nerr++;
            $display("FAIL step_round%0d: got %h want %h", i, od[2], m_od[2]);
         end
      end
   endtask

   task automatic test_round();
      do_reset();
      tick(1'b1, 3'd0, 15'h0003, 5'd2, 1'b0, 1'b1);
      nvec++;
      if (od[2] !== 16'h0002) begin
         nerr++;
         $display("FAIL round_on: got %h want 0002", od[2]);
      end
      nvec++;
      if (od[1] !== 16'h0001) begin
         nerr++;
         $display("FAIL round_off: got %h want 0001", od[1]);
      end
   endtask

   task automatic test_extremes();
      do_reset();
      tick(1'b1, 3'd0, 15'h3FF8, 5'd4, 1'b0, 1'b1);
      tick(1'b1, 3'd0, 15'h4000, 5'd1, 1'b0, 1'b1);
      nvec++;
      if (od[0] !== 16'hFFF8) begin
         nerr++;
         $display("FAIL extreme_lg1: got %h want FFF8", od[0]);
      end
      tick(1'b1, 3'd1, 15'h3FF8, 5'd4, 1'b0, 1'b1);
      tick(1'b1, 3'd1, 15'h4000, 5'd0, 1'b0, 1'b1);
      nvec++;
      if (od[0] !== 16'h8000) begin
         nerr++;
         $display("FAIL extreme_lg0: got %h want 8000", od[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] held [NI];
      logic [14:0] d1;
      logic [14:0] d3;
      do_reset();
      d1 = 15'($urandom);
      d3 = 15'($urandom);
      tick(1'b1, 3'd1, d1, 5'd3, 1'b0, 1'b1);
      for (int k = 0; k < NI; k++) held[k] = od[k];
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 3'd3, d3, 5'd2, 1'b0, 1'b0);
         for (int k = 0; k < NI; k++) begin
            nvec++;
            if (ordy[k] !== 1'b0 || ov[k] !== 1'b1 || oc[k] !== 3'd1 || od[k] !== held[k]) begin
               nerr++;
               $display("FAIL bp_hold inst%0d cyc%0d: got r=%b v=%b c=%0d d=%h want r=0 v=1 c=1 d=%h",
                        k, i, ordy[k], ov[k], oc[k], od[k], held[k]);
            end
         end
      end
      tick(1'b1, 3'd3, d3, 5'd2, 1'b0, 1'b1);
      tick(1'b1, 3'd1, 15'($urandom), 5'd3, 1'b0, 1'b1);
      for (int k = 0; k < NI; k++) begin
         nvec++;
         if (ov[k] !== 1'b1 || oc[k] !== 3'd1 || od[k] !== m_od[k]) begin
            nerr++;
            $display("FAIL bp_isolation inst%0d: got v=%b c=%0d d=%h want v=1 c=1 d=%h",
                     k, ov[k], oc[k], od[k], m_od[k]);
         end
      end
      // Out-of-range channel is consumed without producing a result.
      tick(1'b1, 3'd5, 15'h1234, 5'd1, 1'b0, 1'b1);
      nvec++;
      if (ov[0] !== 1'b0) begin
         nerr++;
         $display("FAIL bad_chan_no_output: got v=%b want 0", ov[0]);
      end
   endtask

   task automatic test_clear();
      do_reset();
      tick(1'b1, 3'd0, 15'h0100, 5'd2, 1'b0, 1'b1);
      tick(1'b1, 3'd0, 15'h0300, 5'd2, 1'b1, 1'b0);
      nvec++;
      if (ordy[0] !== 1'b0 || ov[0] !== 1'b1 || oc[0] !== 3'd0 || od[0] !== 16'h0200) begin
         nerr++;
         $display("FAIL clear_pending: got r=%b v=%b c=%0d d=%h want r=0 v=1 c=0 d=0200",
                  ordy[0], ov[0], oc[0], od[0]);
      end
      tick(1'b0, 3'd0, 15'h0000, 5'd0, 1'b0, 1'b1);
      nvec++;
      if (ov[0] !== 1'b0) begin
         nerr++;
         $display("FAIL clear_drain: got v=%b want 0", ov[0]);
      end
      tick(1'b1, 3'd0, 15'h0AAA, 5'd2, 1'b0, 1'b1);
      nvec++;
      if (od[0] !== 16'h1554) begin
         nerr++;
         $display("FAIL clear_repreload: got %h want 1554", od[0]);
      end
      nvec++;
      if (od[1] !== 16'h0555) begin
         nerr++;
         $display("FAIL clear_avg_zeroed: got %h want 0555", od[1]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      tick(1'b1, 3'd2, 15'h1234, 5'd3, 1'b0, 1'b0);
      #1;
      i_areset_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         nvec++;
         if (ov[k] !== 1'b0 || oc[k] !== 3'd0 || od[k] !== 16'h0000) begin
            nerr++;
            $display("FAIL async_reset inst%0d: got v=%b c=%0d d=%h want v=0 c=0 d=0000",
                     k, ov[k], oc[k], od[k]);
         end
      end
      model_reset();
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_areset_n = 1'b1;
      tick(1'b1, 3'd2, 15'h0123, 5'd3, 1'b0, 1'b1);
      nvec++;
      if (ov[0] !== 1'b1 || od[0] !== 16'h0246) begin
         nerr++;
         $display("FAIL post_reset_preload: got v=%b d=%h want v=1 d=0246", ov[0], od[0]);
      end
   endtask

   task automatic test_random();
      bit          v;
      bit          clr;
      bit          rdy;
      logic [2:0]  ch;
      logic [14:0] d;
      logic [4:0]  lg;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom % 4) != 0;
         ch  = 3'($urandom_range(0, 5));
         d   = 15'($urandom);
         if ($urandom % 8 == 0) d = ($urandom % 2 == 0) ? 15'h4000 : 15'h3FFF;
         lg  = 5'($urandom_range(0, 20));
         clr = ($urandom % 50) == 0;
         rdy = ($urandom % 3) != 0;
         tick(v, ch, d, lg, clr, rdy);
         for (int k = 0; k < NI; k++) begin
            nvec++;
            if (ordy[k] !== ((!m_ov || i_ready) && !i_clear)) begin
               nerr++;
               $display("FAIL rand_ready inst%0d cyc%0d: got %b want %b",
                        k, n, ordy[k], (!m_ov || i_ready) && !i_clear);
            end
            nvec++;
            if (ov[k] !== m_ov) begin
               nerr++;
               $display("FAIL rand_valid inst%0d cyc%0d: got %b want %b", k, n, ov[k], m_ov);
            end
            if (m_ov) begin
               nvec++;
               if (oc[k] !== m_oc || od[k] !== m_od[k]) begin
                  nerr++;
                  $display("FAIL rand_data inst%0d cyc%0d: got c=%0d d=%h want c=%0d d=%h",
                           k, n, oc[k], od[k], m_oc, m_od[k]);
               end
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_preload();
      test_step();
      test_round();
      test_extremes();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/iir_mcavg.md
IIR_MCAVG -- requirements
Module: iir_mcavg

Interface
REQ-001 Parameter IW, default 15: input sample width, signed two's complement.
REQ-002 Parameter OW, default 16: average/output width; OW >= IW.
REQ-003 Parameter NCH, default 4: number of independent channels.
REQ-004 Parameter CW, default 2: channel index width; NCH <= 2^CW.
REQ-005 Parameter LW, default 4: width of the runtime alpha shift input.
REQ-006 Parameter RESET_VALUE, default 0: OW-bit initial average of every channel.
REQ-007 Parameter OPT_PRELOAD, default 1: first sample on an unprimed channel loads the average directly.
REQ-008 Parameter OPT_ROUND, default 1: round-half-up on the shifted adjustment.
REQ-009 i_clk  input  1  sole clock; all state on rising edge.
REQ-010 i_areset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-011 i_valid  input  1  input sample present.
REQ-012 o_ready  output  1  block accepts a sample this cycle.
REQ-013 i_chan  input  CW  channel of the input sample.
REQ-014 i_data  input  IW  input sample.
REQ-015 i_lgalpha  input  LW  log2(1/alpha), sampled with each accepted sample.
REQ-016 i_clear  input  1  synchronous clear of all channel state.
REQ-017 o_valid  output  1  output result present.
REQ-018 i_ready  input  1  downstream accepts the result.
REQ-019 o_chan  output  CW  channel of the result.
REQ-020 o_data  output  OW  updated average of o_chan.

Function
REQ-021 Accept occurs when i_valid && o_ready; o_ready SHALL equal (!o_valid || i_ready) && !i_clear.
REQ-022 Latency: a sample accepted at edge N SHALL appear on o_valid/o_chan/o_data after edge N, as the channel's post-update average.
REQ-023 While o_valid && !i_ready, o_valid, o_chan and o_data SHALL hold; o_valid drops only on a transfer with no new accept.
REQ-024 x = {i_data, (OW-IW) zeros}, signed; diff = x - avg, computed at OW+1 bits (no wrap).
REQ-025 Effective shift s = min(i_lgalpha, OW-1); adj = (diff + (OPT_ROUND && s>0 ? 2^(s-1) : 0)) >>> s, arithmetic.
REQ-026 new avg = avg + adj, SHALL lie between avg and x inclusive, never overflow OW bits; s=0 gives new avg = x.
REQ-027 Each channel owns an OW-bit average and one primed bit; only the accepted channel's state changes.
REQ-028 OPT_PRELOAD=1 and channel unprimed: new avg = x, primed set; OPT_PRELOAD=0: primed ignored, REQ-025 always applies.
REQ-029 Back-to-back accepts to the same channel SHALL use the previous update (no stale read).
REQ-030 i_clear high: all averages to RESET_VALUE, all primed bits cleared at that edge; no accept that cycle; a pending output still completes its handshake.
REQ-031 i_chan >= NCH on accept: sample consumed, no state change, no output produced.

Reset
REQ-032 i_areset_n low, immediately and independent of i_clk: all averages = RESET_VALUE, primed = 0, o_valid = 0, o_chan = 0, o_data = 0.
REQ-033 Reset mid-handshake SHALL discard the pending result; first accept after release behaves as after power-up.

Verification
REQ-034 Preload: reset, i_chan=2, i_data=0x1000, i_lgalpha=4 -> next cycle o_valid=1, o_chan=2, o_data=0x2000.
REQ-035 Step, OPT_PRELOAD=0, OPT_ROUND=0, lgalpha=4: ch0 x=0x1000 repeatedly -> o_data 0x0100, 0x01F0, 0x02D1.
REQ-036 Rounding, OPT_PRELOAD=0, lgalpha=2, avg 0, x=6 -> o_data 2 (OPT_ROUND=0 -> 1).
REQ-037 Extremes: avg 0x7FF0, x=0x8000 (i_data=0x4000), lgalpha=1 -> o_data 0xFFF8; lgalpha=0 -> 0x8000.
REQ-038 Backpressure/isolation: interleave ch1/ch3, hold i_ready low 3 cycles -> o_ready low, outputs stable, no sample lost, ch1 unaffected by ch3.
REQ-039 Clear/reset: i_clear with pending output -> output completes, next ch0 sample preloads; async reset mid-stream -> o_valid=0 without a clock edge.
